// File: rtl/ai_card_feeder.sv
// rtl/ai_card_feeder.sv - paced card feeder reading feature cards from a synchronous RAM
//
// Reads CARD_CNT cards from RAM addresses 0..CARD_CNT-1 on each start. Each card
// goes out as a one-cycle card_out_rdy strobe with its data on card_out.
// Consecutive strobes are at least 3 + GAP cycles apart. While pause is high,
// the next fetch is held off, but a card that has already been fetched is
// always emitted.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset; abandons any run in progress
//   start         run request, sampled only while idle
//   pause         consumer hold-off; delays the next fetch while high
//   mem_addr      RAM read address (the index register, combinational)
//   mem_data      RAM read data, valid the cycle after mem_addr is presented
//   card_out      card value, zero except while card_out_rdy is high
//   card_out_rdy  one-cycle strobe qualifying card_out
//   busy          high whenever a run is in progress
//   done          one-cycle pulse after the last card of a run

module ai_card_feeder #(
    parameter int ADDR_W   = 6,
    parameter int CARD_CNT = 40,
    parameter int GAP      = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              pause,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    output logic [7:0]        card_out,
    output logic              card_out_rdy,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(CARD_CNT - 1);
    localparam logic [3:0]        GAP_LEN  = 4'(GAP);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_EMIT  = 3'd3,
        S_GAP   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] next_idx;
    logic [3:0]        gap_cnt;
    logic [3:0]        next_gap_cnt;

    assign mem_addr = idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            idx          <= '0;
            gap_cnt      <= '0;
            card_out     <= 8'h00;
            card_out_rdy <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= next_state;
            idx          <= next_idx;
            gap_cnt      <= next_gap_cnt;
            // RAM data is only looked at in LOAD, so card_out is zero on every
            // cycle that does not carry a strobe.
            card_out     <= (state == S_LOAD) ? mem_data : 8'h00;
            card_out_rdy <= (state == S_LOAD);
            busy         <= (next_state != S_IDLE);
            done         <= (next_state == S_DONE);
        end
    end

    always_comb begin
        next_state   = state;
        next_idx     = idx;
        next_gap_cnt = gap_cnt;

        case (state)
            S_IDLE: begin
                if (start) begin
                    next_state = S_FETCH;
                    next_idx   = '0;
                end
            end

            S_FETCH: begin
                next_state = S_LOAD;
            end

            S_LOAD: begin
                next_state = S_EMIT;
            end

            S_EMIT: begin
                if (idx == LAST_IDX) begin
                    next_state = S_DONE;
                end else if (GAP_LEN != 4'd0) begin
                    next_state   = S_GAP;
                    next_gap_cnt = GAP_LEN;
                end else if (pause) begin
                    next_state   = S_GAP;
                    next_gap_cnt = 4'd0;
                end else begin
                    next_state = S_FETCH;
                    next_idx   = idx + ADDR_W'(1);
                end
            end

            S_GAP: begin
                // Leave on the cycle the counter would reach zero, so that
                // exactly GAP idle cycles are spent here when pause is low. A
                // count already at zero (pause entry) just waits for pause to
                // drop.
                if (gap_cnt > 4'd1) begin
                    next_gap_cnt = gap_cnt - 4'd1;
                end else begin
                    next_gap_cnt = 4'd0;
                    if (!pause) begin
                        next_state = S_FETCH;
                        next_idx   = idx + ADDR_W'(1);
                    end
                end
            end

            S_DONE: begin
                next_state = S_IDLE;
            end

            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ai_card_feeder.sv
// tb/tb_ai_card_feeder.sv - directed self-checking bench for ai_card_feeder
module tb_ai_card_feeder;

    logic clk;
    logic rst;
    logic pause;
    logic start_a, start_b, start_c, start_d;

    logic [1:0] addr_a, addr_b;
    logic [5:0] addr_c;
    logic [0:0] addr_d;
    logic [7:0] mdat_a, mdat_b, mdat_c, mdat_d;
    logic [7:0] card_a, card_b, card_c, card_d;
    logic       rdy_a, rdy_b, rdy_c, rdy_d;
    logic       busy_a, busy_b, busy_c, busy_d;
    logic       done_a, done_b, done_c, done_d;

    logic [7:0] ram_ab [4];
    logic [7:0] ram_c  [64];
    logic [7:0] ram_d  [2];

    int errors;
    int checks;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ai_card_feeder #(.ADDR_W(2), .CARD_CNT(4), .GAP(0)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .pause(pause), .mem_addr(addr_a),
        .mem_data(mdat_a), .card_out(card_a), .card_out_rdy(rdy_a), .busy(busy_a), .done(done_a));

    ai_card_feeder #(.ADDR_W(2), .CARD_CNT(4), .GAP(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .pause(pause), .mem_addr(addr_b),
        .mem_data(mdat_b), .card_out(card_b), .card_out_rdy(rdy_b), .busy(busy_b), .done(done_b));

    ai_card_feeder #(.ADDR_W(6), .CARD_CNT(40), .GAP(0)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .pause(pause), .mem_addr(addr_c),
        .mem_data(mdat_c), .card_out(card_c), .card_out_rdy(rdy_c), .busy(busy_c), .done(done_c));

    ai_card_feeder #(.ADDR_W(1), .CARD_CNT(1), .GAP(3)) dut_d (
        .clk(clk), .rst(rst), .start(start_d), .pause(pause), .mem_addr(addr_d),
        .mem_data(mdat_d), .card_out(card_d), .card_out_rdy(rdy_d), .busy(busy_d), .done(done_d));

    // Synchronous-read RAM models.
    always @(posedge clk) begin
        mdat_a <= ram_ab[addr_a];
        mdat_b <= ram_ab[addr_b];
        mdat_c <= ram_c[addr_c];
        mdat_d <= ram_d[addr_d];
    end

    // Output view of the instance under test.
    int   sel;
    logic [7:0] o_card;
    logic o_rdy, o_busy, o_done;
    int   o_addr;

    always_comb begin
        o_card = card_a; o_rdy = rdy_a; o_busy = busy_a; o_done = done_a; o_addr = int'(addr_a);
        case (sel)
            1: begin o_card = card_b; o_rdy = rdy_b; o_busy = busy_b; o_done = done_b; o_addr = int'(addr_b); end
            2: begin o_card = card_c; o_rdy = rdy_c; o_busy = busy_c; o_done = done_c; o_addr = int'(addr_c); end
            3: begin o_card = card_d; o_rdy = rdy_d; o_busy = busy_d; o_done = done_d; o_addr = int'(addr_d); end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit in_q(input int q[$], input int v);
        foreach (q[i]) if (q[i] == v) return 1'b1;
        return 1'b0;
    endfunction

    // Per-run expectation tables, filled in before each run_vec call.
    int start_cyc[$], pause_cyc[$];
    int st_cyc[$], st_val[$], done_cyc[$];
    int busy_lo[$], busy_hi[$];
    int addr_cyc[$], addr_val[$];

    task automatic clear_vec();
        start_cyc = {}; pause_cyc = {}; st_cyc = {}; st_val = {}; done_cyc = {};
        busy_lo = {}; busy_hi = {}; addr_cyc = {}; addr_val = {};
    endtask

    // Entered just after a rising edge; cycle 0 is the cycle that follows.
    task automatic run_vec(input string tag, input int sel_i, input int ncyc);
        int  nstrobe;
        bit  s, eb;
        int  er, ev;
        sel = sel_i;
        nstrobe = 0;
        for (int c = 0; c < ncyc; c++) begin
            s = in_q(start_cyc, c);
            start_a = s && (sel_i == 0);
            start_b = s && (sel_i == 1);
            start_c = s && (sel_i == 2);
            start_d = s && (sel_i == 3);
            pause   = in_q(pause_cyc, c);
            #4;
            er = 0; ev = 0;
            foreach (st_cyc[i]) if (st_cyc[i] == c) begin er = 1; ev = st_val[i]; end
            eb = 1'b0;
            foreach (busy_lo[i]) if (c >= busy_lo[i] && c <= busy_hi[i]) eb = 1'b1;
            chk($sformatf("%s c%0d rdy", tag, c), int'(o_rdy), er);
            chk($sformatf("%s c%0d card", tag, c), int'(o_card), ev);
            chk($sformatf("%s c%0d done", tag, c), int'(o_done), int'(in_q(done_cyc, c)));
            chk($sformatf("%s c%0d busy", tag, c), int'(o_busy), int'(eb));
            foreach (addr_cyc[i]) if (addr_cyc[i] == c)
                chk($sformatf("%s c%0d addr", tag, c), o_addr, addr_val[i]);
            if (o_rdy) nstrobe++;
            @(posedge clk); #1;
        end
        start_a = 0; start_b = 0; start_c = 0; start_d = 0; pause = 0;
        chk($sformatf("%s strobe count", tag), nstrobe, st_cyc.size());
    endtask

    int  got_val[$];
    int  got_cyc[$];
    bit  saw_done;

    initial begin
        errors = 0; checks = 0; sel = 0;
        rst = 1'b1; pause = 0;
        start_a = 0; start_b = 0; start_c = 0; start_d = 0;
        ram_ab[0] = 8'h11; ram_ab[1] = 8'h22; ram_ab[2] = 8'h33; ram_ab[3] = 8'h44;
        ram_d[0] = 8'h5A; ram_d[1] = 8'hEE;
        for (int i = 0; i < 64; i++) ram_c[i] = 8'($urandom_range(0, 255));

        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            sel = k;
            #0;
            chk($sformatf("reset%0d busy", k), int'(o_busy), 0);
            chk($sformatf("reset%0d rdy", k), int'(o_rdy), 0);
            chk($sformatf("reset%0d card", k), int'(o_card), 0);
            chk($sformatf("reset%0d done", k), int'(o_done), 0);
            chk($sformatf("reset%0d addr", k), o_addr, 0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // Back-to-back runs; starts at 5 and 13 land while busy, 14 is idle.
        clear_vec();
        start_cyc = '{0, 5, 13, 14};
        st_cyc    = '{3, 6, 9, 12, 17, 20, 23, 26};
        st_val    = '{'h11, 'h22, 'h33, 'h44, 'h11, 'h22, 'h33, 'h44};
        done_cyc  = '{13, 27};
        busy_lo   = '{1, 15};
        busy_hi   = '{13, 27};
        addr_cyc  = '{12};
        addr_val  = '{3};
        run_vec("gap0", 0, 30);

        // Two extra idle cycles between cards.
        clear_vec();
        start_cyc = '{0};
        st_cyc    = '{3, 8, 13, 18};
        st_val    = '{'h11, 'h22, 'h33, 'h44};
        done_cyc  = '{19};
        busy_lo   = '{1};
        busy_hi   = '{19};
        run_vec("gap2", 1, 22);

        // pause seen from the EMIT of card 0 for five sampling edges:
        // the next FETCH slips to cycle 9 and card 1 strobes at 11.
        clear_vec();
        start_cyc = '{0};
        pause_cyc = '{3, 4, 5, 6, 7};
        st_cyc    = '{3, 11, 14, 17};
        st_val    = '{'h11, 'h22, 'h33, 'h44};
        done_cyc  = '{18};
        busy_lo   = '{1};
        busy_hi   = '{18};
        addr_cyc  = '{4, 8, 9};
        addr_val  = '{0, 0, 1};
        run_vec("pause", 0, 21);

        // Reset asserted mid-cycle while card 1 (value 22) is in LOAD.
        clear_vec();
        start_cyc = '{0};
        st_cyc    = '{3};
        st_val    = '{'h11};
        busy_lo   = '{1};
        busy_hi   = '{99};
        run_vec("prerst", 0, 5);
        #2;
        rst = 1'b1;
        #1;
        chk("rst async busy", int'(o_busy), 0);
        chk("rst async rdy", int'(o_rdy), 0);
        chk("rst async card", int'(o_card), 0);
        chk("rst async done", int'(o_done), 0);
        chk("rst async addr", o_addr, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #4;
            chk($sformatf("postrst c%0d rdy", c), int'(o_rdy), 0);
            chk($sformatf("postrst c%0d done", c), int'(o_done), 0);
            chk($sformatf("postrst c%0d busy", c), int'(o_busy), 0);
            @(posedge clk); #1;
        end
        clear_vec();
        start_cyc = '{0};
        st_cyc    = '{3, 6, 9, 12};
        st_val    = '{'h11, 'h22, 'h33, 'h44};
        done_cyc  = '{13};
        busy_lo   = '{1};
        busy_hi   = '{13};
        run_vec("restart", 0, 15);

        // Single-card configuration: GAP is not applied after the last card.
        clear_vec();
        start_cyc = '{0};
        st_cyc    = '{3};
        st_val    = '{'h5A};
        done_cyc  = '{4};
        busy_lo   = '{1};
        busy_hi   = '{4};
        run_vec("one", 3, 7);

        // 40-card run with random contents, captured the way the receiver would.
        sel = 2;
        saw_done = 1'b0;
        start_c = 1'b1;
        for (int c = 0; c < 300 && !saw_done; c++) begin
            #4;
            if (o_rdy) begin
                got_val.push_back(int'(o_card));
                got_cyc.push_back(c);
            end
            if (o_done) saw_done = 1'b1;
            @(posedge clk); #1;
            start_c = 1'b0;
        end
        chk("c40 done seen", int'(saw_done), 1);
        chk("c40 count", got_val.size(), 40);
        if (got_cyc.size() > 0) chk("c40 first strobe cycle", got_cyc[0], 3);
        for (int i = 0; i < got_val.size() && i < 40; i++)
            chk($sformatf("c40 card%0d", i), got_val[i], int'(ram_c[i]));
        for (int i = 1; i < got_cyc.size(); i++)
            chk($sformatf("c40 spacing%0d", i), got_cyc[i] - got_cyc[i-1], 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
